rx_to_mem: RTL and testbench
============================

RX_TO_MEM -- requirements
Module: rx_to_mem

Interface
REQ-001 Parameter row, default 2, row count of each operand matrix.
REQ-002 Parameter column, default 2, column count of each operand matrix; row*column SHALL be between 1 and 32.
REQ-003 Parameter TIMEOUT, default 20_000_000, maximum clk cycles allowed between accepted bytes while loading.
REQ-004 clk  input  1  sole clock, rising-edge active.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start_load  input  1  synchronous to clk; a high sample in IDLE starts a load.
REQ-007 rx_status  input  1  receiver byte-valid level; asynchronous to clk (bclk_x8 domain).
REQ-008 rx_byte  input  8  received data; stable from rx_status rise for at least 4 clk cycles.
REQ-009 write_A  output  1  write strobe for matrix A memory.
REQ-010 write_B  output  1  write strobe for matrix B memory.
REQ-011 write_address  output  6  row-major element index for the active strobe.
REQ-012 write_value  output  8  data for the active strobe.
REQ-013 busy  output  1  high in RECV_A, RECV_B and DONE.
REQ-014 load_done  output  1  one-cycle pulse when both matrices are written.
REQ-015 timeout_err  output  1  sticky flag for an aborted load.

Function
REQ-016 rx_status SHALL pass through a 2-flop synchronizer and a third flop; a byte is accepted on the cycle where stage2=1 and stage3=0.
REQ-017 On acceptance, rx_byte SHALL be captured in the same edge; write_value and write_address SHALL be registered.
REQ-018 The write strobe SHALL be high for exactly 1 cycle, in the 4th cycle after the first clk edge that samples rx_status high.
REQ-019 Holding rx_status high SHALL produce exactly one write; a new byte needs rx_status low for at least 3 clk cycles.
REQ-020 States SHALL be IDLE, RECV_A, RECV_B and DONE.
REQ-021 IDLE->RECV_A on start_load=1: element index cleared to 0, timeout_err cleared, timeout counter cleared.
REQ-022 In IDLE, accepted bytes SHALL be discarded with no strobe.
REQ-023 RECV_A: each accepted byte SHALL assert write_A at the current index, then increment the index.
REQ-024 RECV_A: the byte at index row*column-1 SHALL transition to RECV_B with the index reset to 0.
REQ-025 RECV_B: the same rules SHALL apply using write_B.
REQ-026 RECV_B: the last byte SHALL transition to DONE.
REQ-027 DONE SHALL last 1 cycle, assert load_done in that cycle, then go to IDLE.
REQ-028 The last write_B strobe and load_done SHALL occur in the same cycle.
REQ-029 write_A and write_B SHALL never both be high.
REQ-030 write_address SHALL be zero-extended to 6 bits and never exceed row*column-1.
REQ-031 The timeout counter SHALL increment each cycle in RECV_A/RECV_B and clear on each accepted byte.
REQ-032 On the counter reaching TIMEOUT-1, the block SHALL go to IDLE, set timeout_err and issue no further strobes.
REQ-033 Memory contents already written SHALL be left as-is after a timeout.
REQ-034 If a byte acceptance and a timeout occur in the same cycle, the byte SHALL win: it is written and the counter clears.
REQ-035 start_load SHALL be ignored outside IDLE.
REQ-036 When start_load and a byte acceptance coincide in IDLE, the byte SHALL be discarded and the state enters RECV_A.

Reset
REQ-037 rst low SHALL immediately force: state IDLE, index 0, counter 0, synchronizer flops 0.
REQ-038 rst low SHALL immediately force all outputs 0: write_A, write_B, write_address, write_value, busy, load_done and timeout_err.
REQ-039 Reset mid-load SHALL abort with no strobe emitted after rst falls.
REQ-040 Operation SHALL resume on the first clk edge after rst rises.

Verification
REQ-041 Normal load: start_load, then bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 -> write_A at addresses 0-3 with 11,22,33,44; write_B at 0-3 with 55..88; load_done on the 0x88 strobe cycle; busy then 0.
REQ-042 Latency/level: rx_status held high 50 cycles with 0xA5 -> exactly one write_A, addr 0, value A5, 4th cycle after first sample.
REQ-043 Idle discard: byte 0x3C with no start_load -> no strobe, busy 0.
REQ-044 Timeout (TIMEOUT=100): start, 2 bytes, silence -> IDLE 100 cycles after the 2nd acceptance; timeout_err 1.
REQ-045 Timeout recovery: after REQ-044, a new start_load clears timeout_err and addressing restarts at A addr 0.
REQ-046 Reset mid-load: rst low after 5 bytes -> all outputs 0 at once; after rst high, 8 bytes with no start_load produce no strobes.

Source files
------------

// File: rtl/rx_to_mem.sv
// rx_to_mem: loads two row x column byte matrices (A then B) from a UART-style
// byte receiver into memory via registered write strobes, with an inter-byte
// timeout that aborts a stalled load.
module rx_to_mem #(
  parameter int unsigned row     = 2,
  parameter int unsigned column  = 2,
  parameter int unsigned TIMEOUT = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_load,
  input  logic       rx_status,
  input  logic [7:0] rx_byte,
  output logic       write_A,
  output logic       write_B,
  output logic [5:0] write_address,
  output logic [7:0] write_value,
  output logic       busy,
  output logic       load_done,
  output logic       timeout_err
);

  localparam int unsigned NELEM = row * column;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [5:0]       LAST_IDX = 6'(NELEM - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV_A = 2'd1;
  localparam logic [1:0] S_RECV_B = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [2:0]       sync_q, sync_d;
  logic             acc_q, acc_d;
  logic [7:0]       byte_q, byte_d;
  logic [1:0]       state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_a_q, write_a_d;
  logic             write_b_q, write_b_d;
  logic [5:0]       waddr_q, waddr_d;
  logic [7:0]       wval_q, wval_d;
  logic             busy_q, busy_d;
  logic             load_done_q, load_done_d;
  logic             terr_q, terr_d;
  logic             accept_c;
  logic             in_recv_c;

  assign accept_c  = sync_q[1] & ~sync_q[2];
  assign in_recv_c = (state_q == S_RECV_A) || (state_q == S_RECV_B);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    sync_d      = {sync_q[1:0], rx_status};
    acc_d       = accept_c & in_recv_c;
    byte_d      = accept_c ? rx_byte : byte_q;
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    write_a_d   = 1'b0;
    write_b_d   = 1'b0;
    waddr_d     = waddr_q;
    wval_d      = wval_q;
    load_done_d = 1'b0;
    terr_d      = terr_q;

    case (state_q)
      S_IDLE: begin
        // Bytes seen here are dropped: acc_d is gated by in_recv_c.
        if (start_load) begin
          state_d = S_RECV_A;
          idx_d   = 6'd0;
          cnt_d   = '0;
          terr_d  = 1'b0;
        end
      end
      S_RECV_A, S_RECV_B: begin
        cnt_d = accept_c ? '0 : cnt_q + CNT_W'(1);
        if (acc_q) begin
          write_a_d = (state_q == S_RECV_A);
          write_b_d = (state_q == S_RECV_B);
          waddr_d   = idx_q;
          wval_d    = byte_q;
          if (idx_q == LAST_IDX) begin
            idx_d = 6'd0;
            if (state_q == S_RECV_A) begin
              state_d = S_RECV_B;
            end else begin
              state_d     = S_DONE;
              load_done_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else if (!accept_c && cnt_q == CNT_LAST) begin
          // An arriving byte takes priority over the timeout.
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 3'd0;
      acc_q       <= 1'b0;
      byte_q      <= 8'd0;
      state_q     <= S_IDLE;
      idx_q       <= 6'd0;
      cnt_q       <= '0;
      write_a_q   <= 1'b0;
      write_b_q   <= 1'b0;
      waddr_q     <= 6'd0;
      wval_q      <= 8'd0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      acc_q       <= acc_d;
      byte_q      <= byte_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      write_a_q   <= write_a_d;
      write_b_q   <= write_b_d;
      waddr_q     <= waddr_d;
      wval_q      <= wval_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      terr_q      <= terr_d;
    end
  end

  assign write_A       = write_a_q;
  assign write_B       = write_b_q;
  assign write_address = waddr_q;
  assign write_value   = wval_q;
  assign busy          = busy_q;
  assign load_done     = load_done_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_rx_to_mem.sv
// Directed bench for rx_to_mem: table-driven normal load plus hand-written
// latency, discard, timeout, recovery and mid-load reset sequences.
module tb_rx_to_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_load = 1'b0;
  logic       rx_status = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       write_A, write_B, busy, load_done, timeout_err;
  logic [5:0] write_address;
  logic [7:0] write_value;

  rx_to_mem #(.row(2), .column(2), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .rx_status(rx_status),
    .rx_byte(rx_byte), .write_A(write_A), .write_B(write_B),
    .write_address(write_address), .write_value(write_value), .busy(busy),
    .load_done(load_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_b;
    logic [5:0] addr;
    logic [7:0] val;
    logic       done;
  } ev_t;

  typedef struct {
    logic [7:0] din;
    logic       exp_b;
    logic [5:0] exp_addr;
    logic       exp_done;
  } vec_t;

  ev_t log_q[$];
  int  both_cnt = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  // Record every strobe seen on the falling edge.
  always @(negedge clk) begin
    if (write_A || write_B)
      log_q.push_back('{is_b: write_B, addr: write_address, val: write_value, done: load_done});
    if (write_A && write_B) both_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_ev(input string nm, input int i, input logic b,
                          input logic [5:0] a, input logic [7:0] v, input logic d);
    if (i >= log_q.size()) begin
      check({nm, " missing"}, 32'(log_q.size()), 32'(i + 1));
    end else begin
      check(nm, {16'd0, log_q[i].is_b, log_q[i].addr, log_q[i].val, log_q[i].done},
                {16'd0, b, a, v, d});
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start_load = 1'b1;
    @(posedge clk); #1 start_load = 1'b0;
  endtask

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_status = 1'b1;
    repeat (6) @(posedge clk);
    #1 rx_status = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({write_A, write_B, write_address, write_value, busy, load_done, timeout_err});
  endfunction

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h11, 1'b0, 6'd0, 1'b0};
    vecs[1] = '{8'h22, 1'b0, 6'd1, 1'b0};
    vecs[2] = '{8'h33, 1'b0, 6'd2, 1'b0};
    vecs[3] = '{8'h44, 1'b0, 6'd3, 1'b0};
    vecs[4] = '{8'h55, 1'b1, 6'd0, 1'b0};
    vecs[5] = '{8'h66, 1'b1, 6'd1, 1'b0};
    vecs[6] = '{8'h77, 1'b1, 6'd2, 1'b0};
    vecs[7] = '{8'h88, 1'b1, 6'd3, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_outs", all_outs(), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 check("post_reset_outs", all_outs(), 32'd0);

    // Normal load from the vector table
    log_q.delete();
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    foreach (vecs[i]) send_byte(vecs[i].din);
    check("load_cnt", 32'(log_q.size()), 32'd8);
    foreach (vecs[i])
      check_ev($sformatf("load_ev%0d", i), i, vecs[i].exp_b, vecs[i].exp_addr,
               vecs[i].din, vecs[i].exp_done);
    check("load_busy_end", 32'(busy), 32'd0);

    // Strobe latency and level hold
    log_q.delete();
    do_start();
    rx_byte = 8'hA5;
    rx_status = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("lat_cyc%0d", k), 32'(write_A), (k == 4) ? 32'd1 : 32'd0);
    end
    repeat (44) @(posedge clk);
    #1 rx_status = 1'b0;
    check("level_cnt", 32'(log_q.size()), 32'd1);
    check_ev("level_ev", 0, 1'b0, 6'd0, 8'hA5, 1'b0);
    repeat (110) @(posedge clk);
    #1 check("level_tmo_err", 32'(timeout_err), 32'd1);
    check("level_tmo_busy", 32'(busy), 32'd0);

    // Idle discard
    log_q.delete();
    send_byte(8'h3C);
    check("idle_cnt", 32'(log_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // start_load coincident with an acceptance in IDLE
    log_q.delete();
    rx_byte = 8'h99;
    rx_status = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 start_load = 1'b1;
    @(posedge clk); #1 start_load = 1'b0;
    check("coinc_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1 rx_status = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("coinc_cnt", 32'(log_q.size()), 32'd0);
    send_byte(8'h77);
    check_ev("coinc_next", 0, 1'b0, 6'd0, 8'h77, 1'b0);
    repeat (110) @(posedge clk);
    #1;

    // Timeout after two bytes
    log_q.delete();
    do_start();
    check("tmo_err_clr", 32'(timeout_err), 32'd0);
    send_byte(8'h01);
    rx_byte = 8'h02;
    rx_status = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1 rx_status = 1'b0;
    repeat (96) @(posedge clk);
    #1 check("tmo_pre", 32'({busy, timeout_err}), 32'b10);
    @(posedge clk);
    #1 check("tmo_hit", 32'({busy, timeout_err}), 32'b01);
    repeat (20) @(posedge clk);
    #1 check("tmo_cnt", 32'(log_q.size()), 32'd2);
    check_ev("tmo_ev1", 1, 1'b0, 6'd1, 8'h02, 1'b0);

    // Recovery then reset mid-load
    log_q.delete();
    do_start();
    check("rec_err_clr", 32'(timeout_err), 32'd0);
    send_byte(8'h5A);
    send_byte(8'h5B);
    send_byte(8'h5C);
    send_byte(8'h5D);
    send_byte(8'h5E);
    check_ev("rec_ev0", 0, 1'b0, 6'd0, 8'h5A, 1'b0);
    check_ev("rec_ev4", 4, 1'b1, 6'd0, 8'h5E, 1'b0);
    rx_byte = 8'hEE;
    rx_status = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("rst_pre_strobe", 32'({write_B, write_address, write_value}), {17'd0, 1'b1, 6'd1, 8'hEE});
    #1 rst = 1'b0;
    #1 check("rst_outs", all_outs(), 32'd0);
    log_q.delete();
    repeat (5) @(posedge clk);
    #1 rx_status = 1'b0;
    check("rst_hold_cnt", 32'(log_q.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
    check("post_rst_cnt", 32'(log_q.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    check("a_b_exclusive", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
